// File: rtl/slicem_pkg.sv
// Shared types and config-layout helpers for the SLICEM distributed-RAM slice.
package slicem_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_RAM   = 2'b01,
    MODE_SRL   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  function automatic int unsigned lut_depth(input int unsigned k);
    return 32'd1 << k;
  endfunction

  function automatic int unsigned cfg_width(input int unsigned k, input int unsigned n);
    return n * lut_depth(k) + 3;
  endfunction

  // Config layout: LUT tables at the bottom, then 2-bit mode, then use_cc at the MSB.
  function automatic int unsigned mode_offset(input int unsigned k, input int unsigned n);
    return n * lut_depth(k);
  endfunction

  function automatic int unsigned use_cc_offset(input int unsigned k, input int unsigned n);
    return cfg_width(k, n) - 1;
  endfunction

endpackage

// File: rtl/slicem_lut_mem.sv
// One LUT table: async read, RAM bit write, and shift (config load or SRL).
module slicem_lut_mem
  import slicem_pkg::*;
#(
  parameter int unsigned LUT_INPUTS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  shift_in,
  input  logic                  write_en,
  input  logic [LUT_INPUTS-1:0] write_addr,
  input  logic                  write_data,
  input  logic [LUT_INPUTS-1:0] read_addr,
  output logic                  read_data,
  output logic                  msb
);

  localparam int unsigned DEPTH = lut_depth(LUT_INPUTS);

  logic [DEPTH-1:0] mem_q;

  // Config shift and SRL shift share one path; the top decides which input feeds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (shift_en) begin
      mem_q <= {mem_q[DEPTH-2:0], shift_in};
    end else if (write_en) begin
      mem_q[write_addr] <= write_data;
    end
  end

  assign read_data = mem_q[read_addr];
  assign msb       = mem_q[DEPTH-1];

endmodule

// File: rtl/slicem_dram.sv
// SLICEM slice: NUM_LUTS LUT-RAM/SRL tables, serial config chain, carry chain, output registers.
module slicem_dram
  import slicem_pkg::*;
#(
  parameter int unsigned LUT_INPUTS = 4,
  parameter int unsigned NUM_LUTS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cen,
  input  logic                             config_in,
  output logic                             config_out,
  input  logic [NUM_LUTS*LUT_INPUTS-1:0]   luts_in,
  input  logic                             ci,
  input  logic                             reg_ce,
  input  logic                             write_en,
  input  logic [LUT_INPUTS-1:0]            write_addr,
  input  logic [NUM_LUTS-1:0]              data_in,
  input  logic [NUM_LUTS-1:0]              write_lut_select,
  output logic [NUM_LUTS-1:0]              out,
  output logic [NUM_LUTS-1:0]              sync_out,
  output logic                             co,
  output logic                             srl_out
);

  localparam int unsigned K       = LUT_INPUTS;
  localparam int unsigned DEPTH   = lut_depth(LUT_INPUTS);
  localparam int unsigned CFG_W   = cfg_width(LUT_INPUTS, NUM_LUTS);
  localparam int unsigned MODE_LO = mode_offset(LUT_INPUTS, NUM_LUTS);
  localparam int unsigned CC_BIT  = use_cc_offset(LUT_INPUTS, NUM_LUTS);

  // Upper config bits (mode, use_cc) live here; table bits live in the LUT instances.
  logic [CFG_W-1:MODE_LO] ctl_q;
  logic [NUM_LUTS-1:0]    lut_out;
  logic [NUM_LUTS-1:0]    msb;
  logic [NUM_LUTS-1:0]    sum;
  logic [NUM_LUTS:0]      carry;
  logic [NUM_LUTS-1:0]    sync_q;
  mode_t                  mode;
  logic                   use_cc;
  logic                   ram_wr;
  logic                   srl_sh;

  assign mode   = mode_t'(ctl_q[MODE_LO +: 2]);
  assign use_cc = ctl_q[CC_BIT];
  assign ram_wr = write_en && !cen && (mode == MODE_RAM);
  assign srl_sh = write_en && !cen && (mode == MODE_SRL);

  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
    logic chain_in;
    // The config chain and SRL chain both enter at LUT0 and ripple through each LUT's MSB.
    if (g == 0) begin : g_head
      assign chain_in = cen ? config_in : data_in[0];
    end else begin : g_link
      assign chain_in = msb[g-1];
    end

    slicem_lut_mem #(.LUT_INPUTS(LUT_INPUTS)) u_mem (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en   (cen || (srl_sh && write_lut_select[g])),
      .shift_in   (chain_in),
      .write_en   (ram_wr && write_lut_select[g]),
      .write_addr (write_addr),
      .write_data (data_in[g]),
      .read_addr  (luts_in[K*g +: K]),
      .read_data  (lut_out[g]),
      .msb        (msb[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      sync_q <= '0;
    end else begin
      if (cen) begin
        ctl_q <= {ctl_q[CFG_W-2:MODE_LO], msb[NUM_LUTS-1]};
      end
      if (reg_ce) begin
        sync_q <= out;
      end
    end
  end

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = ci;
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      sum[i]     = lut_out[i] ^ carry[i];
      carry[i+1] = lut_out[i] ? carry[i] : luts_in[K*i + K - 1];
    end
  end

  assign out        = use_cc ? sum : lut_out;
  assign co         = carry[NUM_LUTS];
  assign sync_out   = sync_q;
  assign srl_out    = msb[NUM_LUTS-1];
  assign config_out = ctl_q[CFG_W-1];

endmodule

// File: tb/tb_slicem_dram.sv
// Self-checking bench for slicem_dram: directed corner cases, adder vector table, random vs model.
module tb_slicem_dram;

  localparam int unsigned K  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned CW = N * D + 3;

  logic            clk = 1'b0;
  logic            rst_n, cen, config_in, config_out, ci, reg_ce, write_en, co, srl_out;
  logic [N*K-1:0]  luts_in;
  logic [K-1:0]    write_addr;
  logic [N-1:0]    data_in, write_lut_select, out, sync_out;

  slicem_dram #(.LUT_INPUTS(K), .NUM_LUTS(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cen              (cen),
    .config_in        (config_in),
    .config_out       (config_out),
    .luts_in          (luts_in),
    .ci               (ci),
    .reg_ce           (reg_ce),
    .write_en         (write_en),
    .write_addr       (write_addr),
    .data_in          (data_in),
    .write_lut_select (write_lut_select),
    .out              (out),
    .sync_out         (sync_out),
    .co               (co),
    .srl_out          (srl_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the whole config as one flat vector plus the output register.
  logic [CW-1:0] m_cfg = '0;
  logic [N-1:0]  m_sync = '0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] exp_out;
    logic         exp_co;
  } vec_t;

  vec_t vecs[6];

  // Returns {co, out} for a given config and inputs.
  function automatic logic [N:0] m_eval(input logic [CW-1:0] c, input logic [N*K-1:0] li,
                                        input logic cin);
    logic [N-1:0] p, s;
    logic         cy;
    logic [D-1:0] t;
    cy = cin;
    for (int unsigned i = 0; i < N; i++) begin
      t    = c[D*i +: D];
      p[i] = t[li[K*i +: K]];
      s[i] = p[i] ^ cy;
      cy   = p[i] ? cy : li[K*i + K - 1];
    end
    return {cy, (c[CW-1] ? s : p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [N:0] e;
    e = m_eval(m_cfg, luts_in, ci);
    chk({tag, "_out"},      32'(out),        32'(e[N-1:0]));
    chk({tag, "_co"},       32'(co),         32'(e[N]));
    chk({tag, "_sync"},     32'(sync_out),   32'(m_sync));
    chk({tag, "_srl"},      32'(srl_out),    32'(m_cfg[N*D-1]));
    chk({tag, "_cfg_out"},  32'(config_out), 32'(m_cfg[CW-1]));
  endtask

  task automatic tick();
    logic [N:0]    e;
    logic [CW-1:0] old;
    logic [1:0]    md;
    logic          sin;
    @(posedge clk);
    e   = m_eval(m_cfg, luts_in, ci);
    old = m_cfg;
    md  = m_cfg[N*D +: 2];
    if (!rst_n) begin
      m_cfg  = '0;
      m_sync = '0;
    end else begin
      if (reg_ce) m_sync = e[N-1:0];
      if (cen) begin
        m_cfg = {old[CW-2:0], config_in};
      end else if (write_en && md == 2'b01) begin
        for (int unsigned i = 0; i < N; i++)
          if (write_lut_select[i]) m_cfg[D*i + int'(write_addr)] = data_in[i];
      end else if (write_en && md == 2'b10) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (i == 0) sin = data_in[0];
          else        sin = old[D*i - 1];
          if (write_lut_select[i]) m_cfg[D*i +: D] = {old[D*i +: D-1], sin};
        end
      end
    end
    #1;
  endtask

  task automatic set_idle();
    rst_n = 1'b1; cen = 1'b0; config_in = 1'b0; write_en = 1'b0; reg_ce = 1'b0;
    write_lut_select = '0; data_in = '0; write_addr = '0; ci = 1'b0; luts_in = '0;
  endtask

  task automatic load_cfg(input logic [CW-1:0] v);
    cen = 1'b1;
    for (int k = CW - 1; k >= 0; k--) begin
      config_in = v[k];
      tick();
    end
    cen = 1'b0;
    config_in = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] v;
    logic [95:0]   r;

    vecs[0] = '{a: 4'b1011, b: 4'b0110, cin: 1'b0, exp_out: 4'b0001, exp_co: 1'b1};
    vecs[1] = '{a: 4'b0011, b: 4'b0001, cin: 1'b0, exp_out: 4'b0100, exp_co: 1'b0};
    vecs[2] = '{a: 4'b1111, b: 4'b0001, cin: 1'b0, exp_out: 4'b0000, exp_co: 1'b1};
    vecs[3] = '{a: 4'b0101, b: 4'b0101, cin: 1'b1, exp_out: 4'b1011, exp_co: 1'b0};
    vecs[4] = '{a: 4'b1000, b: 4'b1000, cin: 1'b1, exp_out: 4'b0001, exp_co: 1'b1};
    vecs[5] = '{a: 4'b0000, b: 4'b0000, cin: 1'b1, exp_out: 4'b0001, exp_co: 1'b0};

    // Reset state
    set_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ci = 1'b1;
    luts_in = 16'h8000;
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_co", 32'(co), 32'h1);
    chk("rst_srl", 32'(srl_out), 32'h0);
    chk("rst_cfg_out", 32'(config_out), 32'h0);
    chk("rst_sync", 32'(sync_out), 32'h0);
    ci = 1'b0;
    luts_in = '0;

    // First config bit appears on config_out after exactly CW shifts
    cen = 1'b1;
    config_in = 1'b1;
    tick();
    config_in = 1'b0;
    for (int unsigned n = 0; n < CW - 2; n++) tick();
    chk("cfg_out_early", 32'(config_out), 32'h0);
    tick();
    chk("cfg_out_on_time", 32'(config_out), 32'h1);
    cen = 1'b0;

    // LOGIC mode: LUT0 is a 4-input AND
    v = '0;
    v[15:0] = 16'h8000;
    load_cfg(v);
    luts_in = 16'h000F;
    #1 chk("and_hit", 32'(out), 32'h1);
    luts_in = 16'h000E;
    #1 chk("and_miss", 32'(out), 32'h0);
    chk_model("logic");

    // RAM mode write with read-during-write
    v = '0;
    v[31:16] = 16'hFFFF;
    v[63:48] = 16'hFFFF;
    v[65:64] = 2'b01;
    load_cfg(v);
    luts_in = 16'h5555;
    write_addr = 4'd5;
    data_in = 4'b0101;
    write_lut_select = 4'b0011;
    write_en = 1'b1;
    #1 chk("ram_old", 32'(out), 32'hA);
    tick();
    write_en = 1'b0;
    #1 chk("ram_new", 32'(out), 32'h9);
    luts_in = 16'h4444;
    #1 chk("ram_other_addr", 32'(out), 32'hA);
    chk_model("ram");

    // cen wins over write_en: one config shift, no RAM write
    cen = 1'b1;
    write_en = 1'b1;
    config_in = 1'b1;
    write_lut_select = 4'b1111;
    data_in = 4'b0000;
    write_addr = 4'd0;
    tick();
    cen = 1'b0;
    write_en = 1'b0;
    config_in = 1'b0;
    luts_in = '0;
    #1 chk("prio_shift", 32'(out), 32'h5);
    chk_model("prio");

    // Reset in the middle of a config load
    cen = 1'b1;
    config_in = 1'b1;
    for (int unsigned n = 0; n < 5; n++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cen = 1'b0;
    config_in = 1'b0;
    ci = 1'b1;
    luts_in = 16'h8000;
    #1;
    chk("midrst_out", 32'(out), 32'h0);
    chk("midrst_co", 32'(co), 32'h1);
    chk("midrst_srl", 32'(srl_out), 32'h0);
    chk("midrst_cfg_out", 32'(config_out), 32'h0);
    chk("midrst_sync", 32'(sync_out), 32'h0);
    ci = 1'b0;
    luts_in = '0;

    // SRL mode: one 1 bit travels the 64-deep chain
    v = '0;
    v[65:64] = 2'b10;
    load_cfg(v);
    write_lut_select = 4'b1111;
    write_en = 1'b1;
    data_in = 4'b0001;
    tick();
    data_in = 4'b0000;
    for (int unsigned n = 0; n < N * D - 2; n++) tick();
    chk("srl_early", 32'(srl_out), 32'h0);
    tick();
    chk("srl_on_time", 32'(srl_out), 32'h1);
    write_en = 1'b0;
    write_lut_select = '0;
    chk_model("srl");

    // Carry chain as a 4-bit adder: tables = a XOR b, g = a
    v = {1'b1, 2'b00, {N{16'h6666}}};
    load_cfg(v);
    for (int unsigned t = 0; t < 6; t++) begin
      for (int unsigned i = 0; i < N; i++)
        luts_in[K*i +: K] = {vecs[t].a[i], 1'b0, vecs[t].b[i], vecs[t].a[i]};
      ci = vecs[t].cin;
      #1;
      chk($sformatf("add%0d_out", t), 32'(out), 32'(vecs[t].exp_out));
      chk($sformatf("add%0d_co", t), 32'(co), 32'(vecs[t].exp_co));
    end

    // Random configs and traffic against the model
    for (int unsigned pass = 0; pass < 4; pass++) begin
      set_idle();
      r = {$urandom(), $urandom(), $urandom()};
      v = r[CW-1:0];
      load_cfg(v);
      for (int unsigned n = 0; n < 200; n++) begin
        rst_n = ($urandom_range(0, 99) != 0);
        cen = ($urandom_range(0, 24) == 0);
        config_in = 1'($urandom());
        write_en = 1'($urandom());
        write_lut_select = 4'($urandom());
        data_in = 4'($urandom());
        write_addr = 4'($urandom());
        luts_in = 16'($urandom());
        ci = 1'($urandom());
        reg_ce = 1'($urandom());
        #1 chk_model("rand_pre");
        tick();
        chk_model("rand_post");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
